multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Multi-cycle 32-bit execution unit that consumes the 3-bit ALU control code produced by the ALU control decoder and performs the selected operation. Add, sub and logic ops complete in one cycle. Shifts are iterative, one bit position per cycle. A start/busy/done handshake lets the multi-cycle datapath controller stall while a shift is in progress.

## Interface
Parameters:
- WIDTH, 32: operand and result width. Shift amount is always the low 5 bits of data2_i.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous reset, active-high
- start_i  input  1  request: latch the operands and ALUCtrl_i this cycle
- ALUCtrl_i  input  3  operation code: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 sra, 111 srl
- data1_i  input  WIDTH  operand A; also the value that is shifted
- data2_i  input  WIDTH  operand B; bits [4:0] give the shift amount
- busy_o  output  1  operation in flight; start_i is ignored while high
- done_o  output  1  one-cycle pulse; data_o and zero_o are valid and newly updated
- data_o  output  WIDTH  result register; holds its value until the next done_o
- zero_o  output  1  high when data_o is zero; registered together with data_o

## Operation
- States:
  - IDLE: waiting for a request.
  - EXEC: single-cycle op in progress.
  - SHIFT: iterative shift in progress.
  - DONE: result just produced; lasts one cycle.
- Accept condition: start_i=1 while state is IDLE or DONE. On accept, latch op, A, B and the shift count cnt=data2_i[4:0].
- Accept with op in {000..100}: next state EXEC. EXEC computes the result from the latched operands and writes data_o and zero_o. Next state DONE.
- Accept with op in {101,110,111}: next state SHIFT. The working register holds A.
  - Each SHIFT cycle with cnt≠0 shifts the working register by 1 and decrements cnt:
    - sll: zero fill.
    - srl: zero fill.
    - sra: fills with the latched A[WIDTH-1].
  - In the SHIFT cycle with cnt=0, the working register is written to data_o and zero_o is updated. Next state DONE.
- DONE: done_o=1. If start_i=1, accept the new request (back-to-back). Otherwise go to IDLE.
- busy_o=1 exactly in EXEC and SHIFT. done_o=1 exactly in DONE.
- Arithmetic:
  - Add and sub are modulo 2^WIDTH. Carry/borrow is discarded.
  - sub computes A−B.
  - No overflow flag.
- start_i while busy_o=1 is ignored; latched operands and cnt are unchanged.
- Input changes after acceptance have no effect on the op in flight.
- Reset (rst_i=1 at a rising edge), from any state including mid-shift: state IDLE, cnt=0, busy_o=0, done_o=0, data_o=0, zero_o=1. The in-flight op is abandoned and no done_o is produced for it.
- rst_i has priority over start_i in the same cycle.

## Timing
- Request accepted at edge of cycle N.
- Non-shift op: done_o high in cycle N+2, i.e. one EXEC cycle then DONE. busy_o high in cycle N+1.
- Shift by k (0..31):
  - SHIFT occupies cycles N+1 .. N+1+k.
  - done_o high in cycle N+2+k.
  - busy_o high for k+1 cycles.
  - Worst case sll/sra/srl by 31: done_o in N+33.
- data_o and zero_o change only on the edge that enters DONE. They remain stable in every other cycle.
- Back-to-back throughput: start_i held high gives one non-shift result every 2 cycles. DONE overlaps with the next accept.
- The unit is the only source of its outputs. There are no combinational paths from inputs to busy_o, done_o, data_o or zero_o.

## Test plan
- Reset: assert rst_i during a sll-by-20 after 5 SHIFT cycles.
  - Required next cycle: busy_o=0, done_o=0, data_o=0, zero_o=1.
  - No done_o may appear afterwards.
- add/sub: 0xFFFFFFFF+1 gives data_o=0, zero_o=1, done_o exactly 2 cycles after accept. 5−7 gives 0xFFFFFFFE, zero_o=0.
- Logic: A=0xF0F0F0F0, B=0xFF00FF00.
  - and gives 0xF000F000.
  - or gives 0xFFF0FFF0.
  - xor gives 0x0FF00FF0.
- Shifts: A=0x80000001.
  - sll by 4 gives 0x00000010.
  - srl by 4 gives 0x08000000.
  - sra by 4 gives 0xF8000000, done_o at accept+6.
  - sra by 0 gives 0x80000001, done_o at accept+2.
  - B=0x00000025 shifts by 5 (only bits [4:0] are used).
- Handshake: pulse start_i during busy_o=1 with different operands; the result must equal the first request. Then hold start_i high through DONE and confirm the next op is accepted in the DONE cycle.
- Hold: after done_o, change data1_i/data2_i/ALUCtrl_i with start_i=0 for 10 cycles; data_o and zero_o must stay unchanged and busy_o must stay 0.

Source files
------------

// File: rtl/multicycle_alu.sv
// multicycle_alu: 32-bit execution unit with single-cycle add/sub/logic ops
// and iterative one-bit-per-cycle shifts, behind a start/busy/done handshake.
//
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   start_i    request; latches ALUCtrl_i, data1_i, data2_i when idle or done
//   ALUCtrl_i  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 sra, 111 srl
//   data1_i    operand A (value to shift)
//   data2_i    operand B (bits [4:0] are the shift amount)
//   busy_o     operation in flight (EXEC or SHIFT)
//   done_o     one-cycle pulse when data_o/zero_o are newly updated
//   data_o     result register
//   zero_o     data_o == 0, registered with data_o
module multicycle_alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    localparam int unsigned CNT_W = 5;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [2:0]         op, op_nxt;
    logic [WIDTH-1:0]   a, a_nxt;
    logic [WIDTH-1:0]   b, b_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [WIDTH-1:0]   work, work_nxt;
    logic [WIDTH-1:0]   data_nxt;
    logic               zero_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic               accept;
    logic [WIDTH-1:0]   alu_res;

    // Single-cycle result from the latched operands
    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // Next-state and datapath updates
    always_comb begin
        state_nxt = state;
        op_nxt    = op;
        a_nxt     = a;
        b_nxt     = b;
        cnt_nxt   = cnt;
        work_nxt  = work;
        data_nxt  = data_o;
        zero_nxt  = zero_o;
        accept    = start_i && ((state == S_IDLE) || (state == S_DONE));

        case (state)
            S_EXEC: begin
                data_nxt  = alu_res;
                zero_nxt  = (alu_res == '0);
                state_nxt = S_DONE;
            end
            S_SHIFT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                    case (op)
                        OP_SLL:  work_nxt = {work[WIDTH-2:0], 1'b0};
                        OP_SRA:  work_nxt = {a[WIDTH-1], work[WIDTH-1:1]};
                        default: work_nxt = {1'b0, work[WIDTH-1:1]};
                    endcase
                end else begin
                    data_nxt  = work;
                    zero_nxt  = (work == '0);
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Accept overrides the IDLE/DONE default so DONE overlaps the next request
        if (accept) begin
            op_nxt   = ALUCtrl_i;
            a_nxt    = data1_i;
            b_nxt    = data2_i;
            cnt_nxt  = data2_i[CNT_W-1:0];
            work_nxt = data1_i;
            state_nxt = (ALUCtrl_i == OP_SLL || ALUCtrl_i == OP_SRA || ALUCtrl_i == OP_SRL)
                        ? S_SHIFT : S_EXEC;
        end

        busy_nxt = (state_nxt == S_EXEC) || (state_nxt == S_SHIFT);
        done_nxt = (state_nxt == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            op     <= '0;
            a      <= '0;
            b      <= '0;
            cnt    <= '0;
            work   <= '0;
            data_o <= '0;
            zero_o <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= state_nxt;
            op     <= op_nxt;
            a      <= a_nxt;
            b      <= b_nxt;
            cnt    <= cnt_nxt;
            work   <= work_nxt;
            data_o <= data_nxt;
            zero_o <= zero_nxt;
            busy_o <= busy_nxt;
            done_o <= done_nxt;
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against a plain-arithmetic model.
module tb_multicycle_alu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  ALUCtrl_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;
    logic        zero_o;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_alu #(.WIDTH(32)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .ALUCtrl_i (ALUCtrl_i),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .data_o    (data_o),
        .zero_o    (zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int unsigned sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << sh;
            3'd6:    return 32'($signed(a) >>> sh);
            default: return a >> sh;
        endcase
    endfunction

    function automatic bit is_shift(input logic [2:0] op);
        return op >= 3'd5;
    endfunction

    // Issue one request from a negedge and follow it to done_o; returns at the done negedge
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp, prev_data;
        logic        prev_zero;
        int          lat, busy_cnt, exp_lat;
        bit          stable, seen;
        exp       = model(op, a, b);
        exp_lat   = is_shift(op) ? 2 + int'(b[4:0]) : 2;
        prev_data = data_o;
        prev_zero = zero_o;
        start_i   = 1'b1;
        ALUCtrl_i = op;
        data1_i   = a;
        data2_i   = b;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i   = 1'b0;
        ALUCtrl_i = 3'($urandom_range(0, 7));
        data1_i   = $urandom;
        data2_i   = $urandom;
        lat = 1; busy_cnt = 0; stable = 1'b1; seen = 1'b0;
        while (lat <= 40) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            if (busy_o) busy_cnt++;
            if (data_o !== prev_data || zero_o !== prev_zero) stable = 1'b0;
            @(negedge clk_i);
            lat++;
        end
        check({tag, " seen_done"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        check({tag, " stable_before_done"}, 32'(stable), 32'd1);
        check({tag, " data"}, data_o, exp);
        check({tag, " zero"}, 32'(zero_o), 32'(exp == 32'd0));
    endtask

    initial begin
        logic [31:0] hold_d;
        logic        hold_z;
        int          dones;
        bit          seen;

        rst_i = 1'b1; start_i = 1'b0; ALUCtrl_i = '0; data1_i = '0; data2_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst data", data_o, 32'd0);
        check("rst zero", 32'(zero_o), 32'd1);

        // Directed arithmetic and logic
        run_op("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd1);
        run_op("sub_neg",  3'd1, 32'd5, 32'd7);
        check("sub_neg literal", data_o, 32'hFFFF_FFFE);
        run_op("and", 3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and literal", data_o, 32'hF000_F000);
        run_op("or",  3'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("or literal", data_o, 32'hFFF0_FFF0);
        run_op("xor", 3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("xor literal", data_o, 32'h0FF0_0FF0);

        // Directed shifts
        run_op("sll4", 3'd5, 32'h8000_0001, 32'd4);
        check("sll4 literal", data_o, 32'h0000_0010);
        run_op("srl4", 3'd7, 32'h8000_0001, 32'd4);
        check("srl4 literal", data_o, 32'h0800_0000);
        run_op("sra4", 3'd6, 32'h8000_0001, 32'd4);
        check("sra4 literal", data_o, 32'hF800_0000);
        run_op("sra0", 3'd6, 32'h8000_0001, 32'd0);
        check("sra0 literal", data_o, 32'h8000_0001);
        run_op("srl_b25", 3'd7, 32'h8000_0001, 32'h0000_0025);
        check("srl_b25 literal", data_o, 32'h0400_0000);
        run_op("sll31", 3'd5, 32'h8000_0001, 32'd31);
        run_op("sra31", 3'd6, 32'h8000_0000, 32'd31);

        // Reset during sll by 20 after 5 SHIFT cycles
        @(negedge clk_i);
        start_i = 1'b1; ALUCtrl_i = 3'd5; data1_i = 32'h0000_0003; data2_i = 32'd20;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midshift_rst busy", 32'(busy_o), 32'd0);
        check("midshift_rst done", 32'(done_o), 32'd0);
        check("midshift_rst data", data_o, 32'd0);
        check("midshift_rst zero", 32'(zero_o), 32'd1);
        dones = 0;
        repeat (30) begin
            @(negedge clk_i);
            if (done_o) dones++;
        end
        check("midshift_rst no_done", 32'(dones), 32'd0);

        // start_i during busy is ignored
        start_i = 1'b1; ALUCtrl_i = 3'd7; data1_i = 32'hDEAD_BEEF; data2_i = 32'd6;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        @(negedge clk_i);
        start_i = 1'b1; ALUCtrl_i = 3'd0; data1_i = 32'h1234_5678; data2_i = 32'h1;
        @(negedge clk_i);
        start_i = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check("ignore seen_done", 32'(seen), 32'd1);
        check("ignore data", data_o, model(3'd7, 32'hDEAD_BEEF, 32'd6));

        // Back-to-back: start held high, second op accepted in the DONE cycle
        @(negedge clk_i);
        start_i = 1'b1; ALUCtrl_i = 3'd0; data1_i = 32'd100; data2_i = 32'd23;
        @(posedge clk_i);
        @(negedge clk_i);
        ALUCtrl_i = 3'd4; data1_i = 32'hAAAA_0000; data2_i = 32'h00FF_00FF;
        check("b2b exec busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        check("b2b first done", 32'(done_o), 32'd1);
        check("b2b first data", data_o, 32'd123);
        @(negedge clk_i);
        start_i = 1'b0;
        check("b2b second busy", 32'(busy_o), 32'd1);
        check("b2b second nodone", 32'(done_o), 32'd0);
        @(negedge clk_i);
        check("b2b second done", 32'(done_o), 32'd1);
        check("b2b second data", data_o, 32'hAA55_00FF);

        // Hold: outputs stable with start_i low and inputs toggling
        hold_d = data_o;
        hold_z = zero_o;
        repeat (10) begin
            @(negedge clk_i);
            ALUCtrl_i = 3'($urandom_range(0, 7));
            data1_i = $urandom;
            data2_i = $urandom;
            check("hold data", data_o, hold_d);
            check("hold zero", 32'(zero_o), 32'(hold_z));
            check("hold busy", 32'(busy_o), 32'd0);
        end

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 4 == 0) a = 32'd0;
            if (i % 5 == 0) b = a;
            run_op($sformatf("rand%0d", i), op, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
